// File: rtl/led_status_multi_pkg.sv
// Purpose: shared colours, byte positions, clamp and ADC scan state encoding for the LED status block.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package led_status_multi_pkg;

    // Colours are packed {G,R,B}, one byte each.
    localparam int G_LSB = 16;
    localparam int R_LSB = 8;
    localparam int B_LSB = 0;

    localparam logic [23:0] COLOR_RED    = 24'h007000;
    localparam logic [23:0] COLOR_GREEN  = 24'h700000;
    localparam logic [23:0] COLOR_BLUE   = 24'h000070;
    localparam logic [23:0] COLOR_PURPLE = 24'h005050;
    localparam logic [23:0] COLOR_YELLOW = 24'h505000;
    localparam logic [23:0] COLOR_WHITE  = 24'h303030;

    // Ceiling on the ADC level added to WHITE; 0x30 + 0xBE stays below 0x100,
    // so the add into a single byte never carries into its neighbour.
    localparam logic [7:0] ADC_CLAMP = 8'hBE;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_CMP      = 3'd2,
        ST_CLAMP    = 3'd3,
        ST_COLOR    = 3'd4,
        ST_WAIT_LOW = 3'd5
    } adc_state_t;

endpackage

// File: rtl/led_status_multi_dim.sv
// Purpose: scales each byte of a 24-bit colour by (brightness+1)/256 and registers it.
// Latency: 1 dataclk cycle from color_in/brightness to color_out.
// Backpressure: none; free-running register, output cleared by reset_n.
// Ports: dataclk, reset_n (async active-low), brightness[7:0], color_in[23:0] -> color_out[23:0].
module led_dim (
    input  logic        dataclk,
    input  logic        reset_n,
    input  logic [7:0]  brightness,
    input  logic [23:0] color_in,
    output logic [23:0] color_out
);

    // brightness+1 in 9 bits: 0xFF becomes 0x100, so the >>8 is an exact identity.
    logic [8:0] bright_p1;
    assign bright_p1 = {1'b0, brightness} + 9'd1;

    always_ff @(posedge dataclk or negedge reset_n) begin
        if (!reset_n) begin
            color_out <= '0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                color_out[k*8 +: 8] <= 8'(({9'd0, color_in[k*8 +: 8]} * {8'd0, bright_p1}) >> 8);
            end
        end
    end

endmodule

// File: rtl/led_status_multi.sv
// Purpose: front-panel / headstage-port LED colour generation (connect, blink, TTL activity, ADC level).
// Latency: 1 cycle from colour select to outputs; port connect flags add 1 more; ADC colour lands ~19 cycles after a tick.
// Backpressure: none; sample_tick rising edges arriving while an ADC scan is busy are dropped by the scan only.
// Ports: dataclk, reset_n, sample_tick, running, stream_en/stream_sel, dac_en, ttl_in, adc_data, brightness
//        -> led_port (N_PORTS x 24), led_ttl_in, led_ttl_out, led_adc, led_dac (24 each, {G,R,B}).
module led_status_multi
    import led_status_multi_pkg::*;
#(
    parameter int              N_PORTS       = 4,
    parameter int              N_STREAMS     = 16,
    parameter int              SEL_W         = 4,
    parameter int              N_ADC         = 8,
    parameter int              ADC_W         = 16,
    parameter logic [ADC_W-1:0] ADC_OFFSET   = 16'h0FFF,
    parameter int              BLINK_BITS    = 13,
    parameter int              TTL_HOLD_BITS = 12,
    parameter int              N_TTL         = 8
) (
    input  logic                       dataclk,
    input  logic                       reset_n,
    input  logic                       sample_tick,
    input  logic                       running,
    input  logic [N_STREAMS-1:0]       stream_en,
    input  logic [N_STREAMS*SEL_W-1:0] stream_sel,
    input  logic [7:0]                 dac_en,
    input  logic [N_TTL-1:0]           ttl_in,
    input  logic [N_ADC*ADC_W-1:0]     adc_data,
    input  logic [7:0]                 brightness,
    output logic [N_PORTS*24-1:0]      led_port,
    output logic [23:0]                led_ttl_in,
    output logic [23:0]                led_ttl_out,
    output logic [23:0]                led_adc,
    output logic [23:0]                led_dac
);

    localparam int CH_W = (N_ADC > 1) ? $clog2(N_ADC) : 1;
    localparam logic [CH_W-1:0]          LAST_CH   = CH_W'(N_ADC - 1);
    localparam logic [CH_W-1:0]          CH_ONE    = {{(CH_W-1){1'b0}}, 1'b1};
    localparam logic [BLINK_BITS-1:0]    BLINK_ONE = {{(BLINK_BITS-1){1'b0}}, 1'b1};
    localparam logic [TTL_HOLD_BITS-1:0] HOLD_ONE  = {{(TTL_HOLD_BITS-1){1'b0}}, 1'b1};
    localparam logic [ADC_W-1:0]         SIG_ONE   = {{(ADC_W-1){1'b0}}, 1'b1};
    localparam logic [ADC_W-1:0]         SIG_MIN   = {1'b1, {(ADC_W-1){1'b0}}};

    // ---------------- tick detect ----------------
    logic sample_tick_q;
    logic tick;
    assign tick = sample_tick & ~sample_tick_q;

    // ---------------- port connect ----------------
    // Selects fold onto 2*N_PORTS slots; each port owns two adjacent slots.
    logic [N_PORTS-1:0] conn_d, conn_q;

    always_comb begin
        conn_d = '0;
        for (int i = 0; i < N_STREAMS; i++) begin
            for (int p = 0; p < N_PORTS; p++) begin
                if (stream_en[i] &&
                    (((int'(stream_sel[i*SEL_W +: SEL_W]) % (2*N_PORTS)) / 2) == p)) begin
                    conn_d[p] = 1'b1;
                end
            end
        end
    end

    // ---------------- blink / TTL hold ----------------
    logic [BLINK_BITS-1:0]    blink_cnt;
    logic [TTL_HOLD_BITS-1:0] hold_cnt;
    logic [N_TTL-1:0]         ttl_last;
    logic [23:0]              blink_color;

    assign blink_color = blink_cnt[BLINK_BITS-1] ? COLOR_BLUE : COLOR_GREEN;

    always_ff @(posedge dataclk or negedge reset_n) begin
        if (!reset_n) begin
            sample_tick_q <= 1'b0;
            conn_q        <= '0;
            blink_cnt     <= '0;
            hold_cnt      <= '0;
            ttl_last      <= '0;
        end else begin
            sample_tick_q <= sample_tick;
            conn_q        <= conn_d;
            if (tick) begin
                blink_cnt <= blink_cnt + BLINK_ONE;
                ttl_last  <= ttl_in;
                // Any edge restarts the hold; otherwise count up until it wraps to 0 and parks.
                if (ttl_in != ttl_last) begin
                    hold_cnt <= HOLD_ONE;
                end else if (hold_cnt != '0) begin
                    hold_cnt <= hold_cnt + HOLD_ONE;
                end
            end
        end
    end

    // ---------------- ADC level scan ----------------
    adc_state_t       state, state_nxt;
    logic [CH_W-1:0]  ch;
    logic [ADC_W-1:0] sig, sig_abs, max_abs;
    logic             max_neg;
    logic [7:0]       sum;
    logic [23:0]      adc_color;

    // |most negative| does not fit; saturate it to the largest positive value.
    always_comb begin
        sig_abs = sig;
        if (sig[ADC_W-1]) begin
            sig_abs = (sig == SIG_MIN) ? ~SIG_MIN : (~sig + SIG_ONE);
        end
    end

    always_ff @(posedge dataclk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_WAIT_LOW;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:     if (tick) state_nxt = ST_LOAD;
            ST_LOAD:     state_nxt = ST_CMP;
            ST_CMP:      state_nxt = (ch == LAST_CH) ? ST_CLAMP : ST_LOAD;
            ST_CLAMP:    state_nxt = ST_COLOR;
            ST_COLOR:    state_nxt = ST_WAIT_LOW;
            ST_WAIT_LOW: if (!sample_tick) state_nxt = ST_IDLE;
            default:     state_nxt = ST_WAIT_LOW;
        endcase
    end

    always_ff @(posedge dataclk or negedge reset_n) begin
        if (!reset_n) begin
            ch        <= '0;
            sig       <= '0;
            max_abs   <= '0;
            max_neg   <= 1'b0;
            sum       <= '0;
            adc_color <= COLOR_WHITE;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (tick) begin
                        ch      <= '0;
                        max_abs <= '0;
                        max_neg <= 1'b0;
                    end
                end
                ST_LOAD: sig <= adc_data[ch*ADC_W +: ADC_W] - ADC_OFFSET;
                ST_CMP: begin
                    // Strictly greater: on a tie the earlier channel keeps its sign.
                    if (sig_abs > max_abs) begin
                        max_abs <= sig_abs;
                        max_neg <= sig[ADC_W-1];
                    end
                    if (ch != LAST_CH) ch <= ch + CH_ONE;
                end
                ST_CLAMP: begin
                    sum <= (max_abs[ADC_W-1 -: 8] > ADC_CLAMP) ? ADC_CLAMP : max_abs[ADC_W-1 -: 8];
                end
                ST_COLOR: begin
                    adc_color <= COLOR_WHITE;
                    if (max_neg) adc_color[R_LSB +: 8] <= COLOR_WHITE[R_LSB +: 8] + sum;
                    else         adc_color[G_LSB +: 8] <= COLOR_WHITE[G_LSB +: 8] + sum;
                end
                default: ;
            endcase
        end
    end

    // ---------------- colour select ----------------
    logic [N_PORTS*24-1:0] port_color;
    logic [23:0]           ttl_in_color, dac_color, adc_sel_color;

    always_comb begin
        port_color = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            if (!conn_q[p])    port_color[p*24 +: 24] = COLOR_RED;
            else if (!running) port_color[p*24 +: 24] = COLOR_GREEN;
            else               port_color[p*24 +: 24] = blink_color;
        end
        ttl_in_color  = (running && (hold_cnt != '0)) ? COLOR_YELLOW : COLOR_PURPLE;
        dac_color     = ((dac_en == 8'd0) || !running) ? COLOR_PURPLE : blink_color;
        adc_sel_color = running ? adc_color : COLOR_PURPLE;
    end

    // ---------------- dimmed, registered outputs ----------------
    for (genvar p = 0; p < N_PORTS; p++) begin : g_port_dim
        led_dim u_dim_port (
            .dataclk(dataclk), .reset_n(reset_n), .brightness(brightness),
            .color_in(port_color[p*24 +: 24]), .color_out(led_port[p*24 +: 24])
        );
    end

    led_dim u_dim_ttl_in (
        .dataclk(dataclk), .reset_n(reset_n), .brightness(brightness),
        .color_in(ttl_in_color), .color_out(led_ttl_in)
    );
    led_dim u_dim_ttl_out (
        .dataclk(dataclk), .reset_n(reset_n), .brightness(brightness),
        .color_in(COLOR_PURPLE), .color_out(led_ttl_out)
    );
    led_dim u_dim_adc (
        .dataclk(dataclk), .reset_n(reset_n), .brightness(brightness),
        .color_in(adc_sel_color), .color_out(led_adc)
    );
    led_dim u_dim_dac (
        .dataclk(dataclk), .reset_n(reset_n), .brightness(brightness),
        .color_in(dac_color), .color_out(led_dac)
    );

endmodule

// File: tb/tb_led_status_multi.sv
// Purpose: self-checking bench for led_status_multi; tick-level reference model plus literal spot checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_led_status_multi;

    localparam int NP = 4;
    localparam int NS = 16;
    localparam int SW = 4;
    localparam int NA = 8;
    localparam int AW = 16;

    logic              dataclk = 1'b0;
    logic              reset_n;
    logic              sample_tick;
    logic              running;
    logic [NS-1:0]     stream_en;
    logic [NS*SW-1:0]  stream_sel;
    logic [7:0]        dac_en;
    logic [7:0]        ttl_in;
    logic [NA*AW-1:0]  adc_data;
    logic [7:0]        brightness;
    logic [NP*24-1:0]  led_port;
    logic [23:0]       led_ttl_in, led_ttl_out, led_adc, led_dac;

    always #5 dataclk = ~dataclk;

    led_status_multi #(
        .N_PORTS(NP), .N_STREAMS(NS), .SEL_W(SW), .N_ADC(NA), .ADC_W(AW),
        .ADC_OFFSET(16'h0FFF), .BLINK_BITS(13), .TTL_HOLD_BITS(12), .N_TTL(8)
    ) dut (
        .dataclk(dataclk), .reset_n(reset_n), .sample_tick(sample_tick), .running(running),
        .stream_en(stream_en), .stream_sel(stream_sel), .dac_en(dac_en), .ttl_in(ttl_in),
        .adc_data(adc_data), .brightness(brightness), .led_port(led_port),
        .led_ttl_in(led_ttl_in), .led_ttl_out(led_ttl_out), .led_adc(led_adc), .led_dac(led_dac)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %06h expected %06h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [23:0] dim(input logic [23:0] c, input logic [7:0] b);
        logic [23:0] r;
        for (int k = 0; k < 3; k++) r[k*8 +: 8] = 8'((int'(c[k*8 +: 8]) * (int'(b) + 1)) / 256);
        return r;
    endfunction

    // Largest |sample - mid| across channels, first channel wins ties; level = its top byte, capped at BE.
    function automatic logic [23:0] adc_expect(input logic [NA*AW-1:0] d);
        int  best;
        bit  neg;
        int  lvl;
        best = 0;
        neg  = 1'b0;
        for (int c = 0; c < NA; c++) begin
            int s;
            int a;
            s = int'(d[c*AW +: AW]) - 'h0FFF;
            if (s >= 32768) s -= 65536;
            a = (s < 0) ? ((s == -32768) ? 32767 : -s) : s;
            if (a > best) begin
                best = a;
                neg  = (s < 0);
            end
        end
        lvl = best / 256;
        if (lvl > 'hBE) lvl = 'hBE;
        return neg ? {8'h30, 8'(48 + lvl), 8'h30} : {8'(48 + lvl), 8'h30, 8'h30};
    endfunction

    bit          track_adc = 1'b0;
    bit          m_st_prev = 1'b0;
    int          m_ticks = 0;
    int          m_last_chg = -1;
    logic [7:0]  m_ttl_prev = '0;
    bit          m_conn [NP];
    logic [23:0] m_adc_col = 24'h303030;
    logic [23:0] m_adc_pend = 24'h303030;
    bit          m_adc_known = 1'b1;
    int          m_adc_age = -1;
    logic [23:0] e_port [NP];
    logic [23:0] e_ttl_in = '0, e_ttl_out = '0, e_adc = '0, e_dac = '0;
    bit          e_adc_vld = 1'b1;
    logic [23:0] m_blink, m_c;
    bit          m_hold_on;

    initial begin
        for (int p = 0; p < NP; p++) begin
            m_conn[p] = 1'b0;
            e_port[p] = '0;
        end
        forever begin
            @(posedge dataclk or negedge reset_n);
            if (!reset_n) begin
                m_st_prev   = 1'b0;
                m_ticks     = 0;
                m_last_chg  = -1;
                m_ttl_prev  = '0;
                m_adc_col   = 24'h303030;
                m_adc_known = 1'b1;
                m_adc_age   = -1;
                for (int p = 0; p < NP; p++) begin
                    m_conn[p] = 1'b0;
                    e_port[p] = '0;
                end
                e_ttl_in = '0; e_ttl_out = '0; e_adc = '0; e_dac = '0;
                e_adc_vld = 1'b1;
            end else begin
                // What the outputs show after this edge, from state before it.
                m_blink = ((m_ticks % 8192) >= 4096) ? 24'h000070 : 24'h700000;
                for (int p = 0; p < NP; p++) begin
                    m_c = !m_conn[p] ? 24'h007000 : (!running ? 24'h700000 : m_blink);
                    e_port[p] = dim(m_c, brightness);
                end
                m_hold_on = (m_last_chg >= 0) && ((m_ticks - 1 - m_last_chg) < 4095);
                e_ttl_in  = dim((running && m_hold_on) ? 24'h505000 : 24'h005050, brightness);
                e_ttl_out = dim(24'h005050, brightness);
                e_dac     = dim((dac_en != 0 && running) ? m_blink : 24'h005050, brightness);
                e_adc     = dim(running ? m_adc_col : 24'h005050, brightness);
                e_adc_vld = !running || m_adc_known;
                // Advance the model with inputs seen at this edge.
                if (sample_tick && !m_st_prev) begin
                    if (ttl_in != m_ttl_prev) m_last_chg = m_ticks;
                    m_ttl_prev  = ttl_in;
                    m_ticks++;
                    m_adc_known = 1'b0;
                    m_adc_age   = track_adc ? 0 : -1;
                    if (track_adc) m_adc_pend = adc_expect(adc_data);
                end else if (m_adc_age >= 0) begin
                    m_adc_age++;
                    if (m_adc_age == 22) begin
                        m_adc_col   = m_adc_pend;
                        m_adc_known = 1'b1;
                        m_adc_age   = -1;
                    end
                end
                m_st_prev = sample_tick;
                for (int p = 0; p < NP; p++) begin
                    m_conn[p] = 1'b0;
                    for (int i = 0; i < NS; i++) begin
                        if (stream_en[i] && (((int'(stream_sel[i*SW +: SW]) % (2*NP)) / 2) == p))
                            m_conn[p] = 1'b1;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(posedge dataclk);
            #2;
            for (int p = 0; p < NP; p++) check("model_port", led_port[p*24 +: 24], e_port[p]);
            check("model_ttl_in", led_ttl_in, e_ttl_in);
            check("model_ttl_out", led_ttl_out, e_ttl_out);
            check("model_dac", led_dac, e_dac);
            if (e_adc_vld) check("model_adc", led_adc, e_adc);
        end
    end

    // ---------------- stimulus ----------------
    task automatic settle();
        repeat (3) @(negedge dataclk);
    endtask

    task automatic fast_ticks(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge dataclk); sample_tick = 1'b1;
            @(negedge dataclk); sample_tick = 1'b0;
        end
        settle();
    endtask

    task automatic slow_tick();
        repeat (30) @(negedge dataclk);
        sample_tick = 1'b1;
        @(negedge dataclk);
        sample_tick = 1'b0;
        repeat (30) @(negedge dataclk);
    endtask

    task automatic set_adc(input int ca, input logic [15:0] va, input int cb, input logic [15:0] vb);
        adc_data = {NA{16'h0FFF}};
        adc_data[ca*AW +: AW] = va;
        adc_data[cb*AW +: AW] = vb;
    endtask

    int          v_ca [7] = '{3, 0, 5, 1, 1, 7, 0};
    logic [15:0] v_va [7] = '{16'hBFFF, 16'hFFFF, 16'h3344, 16'h1FFF, 16'hFFFF, 16'h8FFF, 16'h0FFF};
    int          v_cb [7] = '{3, 0, 5, 2, 2, 7, 0};
    logic [15:0] v_vb [7] = '{16'hBFFF, 16'hFFFF, 16'h3344, 16'hFFFF, 16'h1FFF, 16'h8FFF, 16'h0FFF};
    logic [23:0] v_ex [7] = '{24'h308030, 24'h304030, 24'h533030, 24'h403030,
                              24'h304030, 24'h30AF30, 24'h303030};

    initial begin
        reset_n = 1'b0; sample_tick = 1'b0; running = 1'b0;
        stream_en = '0; stream_sel = '0; dac_en = '0; ttl_in = '0;
        adc_data = {NA{16'h0FFF}}; brightness = 8'hFF;
        repeat (3) @(negedge dataclk);
        check("rst_port0", led_port[23:0], 24'h000000);
        check("rst_adc", led_adc, 24'h000000);
        check("rst_ttl_out", led_ttl_out, 24'h000000);

        reset_n = 1'b1;
        settle();
        check("idle_port0_red", led_port[23:0], 24'h007000);
        check("ttl_out_purple", led_ttl_out, 24'h005050);
        check("adc_idle_purple", led_adc, 24'h005050);
        check("dac_idle_purple", led_dac, 24'h005050);

        // Stream 3 with select 9 folds to slot 1 -> port 0.
        stream_en[3] = 1'b1; stream_sel[3*SW +: SW] = 4'd9;
        settle();
        check("sel9_port0_green", led_port[0*24 +: 24], 24'h700000);
        check("sel9_port1_red", led_port[1*24 +: 24], 24'h007000);
        // Stream 5 with select 11 folds to slot 3 -> port 1.
        stream_en[5] = 1'b1; stream_sel[5*SW +: SW] = 4'd11;
        settle();
        check("sel11_port1_green", led_port[1*24 +: 24], 24'h700000);
        check("port3_red", led_port[3*24 +: 24], 24'h007000);

        // Running: blink and TTL hold, ticks counted from 0.
        running = 1'b1; dac_en = 8'h01; ttl_in = 8'h01;
        fast_ticks(100);
        check("blink_100_green", led_port[1*24 +: 24], 24'h700000);
        check("ttl_100_yellow", led_ttl_in, 24'h505000);
        fast_ticks(3990);
        check("ttl_4090_yellow", led_ttl_in, 24'h505000);
        check("blink_4090_green", led_port[1*24 +: 24], 24'h700000);
        fast_ticks(10);
        check("blink_4100_blue", led_port[1*24 +: 24], 24'h000070);
        check("dac_4100_blue", led_dac, 24'h000070);
        check("ttl_4100_purple", led_ttl_in, 24'h005050);
        fast_ticks(100);
        ttl_in = 8'h00;
        fast_ticks(2000);
        ttl_in = 8'h01;
        fast_ticks(2200);
        check("ttl_8400_yellow", led_ttl_in, 24'h505000);
        check("blink_8400_green", led_port[1*24 +: 24], 24'h700000);
        fast_ticks(2000);
        check("ttl_10400_purple", led_ttl_in, 24'h005050);

        // ADC scans with isolated ticks.
        track_adc = 1'b1;
        for (int v = 0; v < 7; v++) begin
            set_adc(v_ca[v], v_va[v], v_cb[v], v_vb[v]);
            slow_tick();
            check($sformatf("adc_vec%0d", v), led_adc, v_ex[v]);
        end

        // Brightness scaling.
        running = 1'b0; brightness = 8'h7F;
        settle();
        check("dim_green", led_port[0*24 +: 24], 24'h380000);
        check("dim_red", led_port[2*24 +: 24], 24'h003800);
        check("dim_purple", led_ttl_out, 24'h002828);

        // Reset in the middle of a scan.
        brightness = 8'hFF; running = 1'b1;
        set_adc(3, 16'hBFFF, 3, 16'hBFFF);
        settle();
        @(negedge dataclk); sample_tick = 1'b1;
        @(negedge dataclk); sample_tick = 1'b0;
        repeat (6) @(negedge dataclk);
        reset_n = 1'b0;
        #1;
        check("midscan_rst_port", led_port[23:0], 24'h000000);
        check("midscan_rst_adc", led_adc, 24'h000000);
        check("midscan_rst_dac", led_dac, 24'h000000);
        repeat (2) @(negedge dataclk);
        reset_n = 1'b1;
        settle();
        check("post_rst_adc_white", led_adc, 24'h303030);
        set_adc(7, 16'h8FFF, 7, 16'h8FFF);
        slow_tick();
        check("post_rst_scan", led_adc, 24'h30AF30);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
